gfx_fetch: RTL and testbench

GFX_FETCH -- requirements
Module: gfx_fetch

---
 rtl/gfx_fetch.sv | 259 +++++++++++++++++++++++++
 tb/tb_gfx_fetch.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_fetch.sv
// -----------------------------------------------------------------------------
// gfx_fetch -- per-line background / sprite fetch sequencer.
//
// On each start pulse the block walks one display line. It fetches either
// tile-map entries plus their pattern words (tile mode) or raw bitmap words
// (bitmap mode). It then optionally scans the sprite attribute table and
// fetches pattern words for the sprites that cover the line. Every fetched
// 8-pixel group goes to the renderer as one command through a valid/ready
// handshake. Only one command is outstanding at a time.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   tilemode           1 = tile map layer, 0 = 320-pixel bitmap layer
//   sprites_enable     scan sprites after the background
//   scroll_x/scroll_y  background scroll offsets
//   spr_sel            sprite attribute index (registered)
//   spr_*              attributes of sprite spr_sel (combinational)
//   vaddr / vdata      VRAM word address (registered) / data for it
//   vline, start       line to fetch, single-cycle start pulse
//   cmd_*              render command: valid/ready, column, pixels, flags
//   busy               line in progress or command still pending
//   spr_overflow       more on-line sprites than MAX_SPR_LINE
// -----------------------------------------------------------------------------
module gfx_fetch #(
    parameter int NUM_SPRITES  = 64,
    parameter int MAX_SPR_LINE = 16,
    parameter int NUM_COLS     = 41
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tilemode,
    input  logic                           sprites_enable,
    input  logic [8:0]                     scroll_x,
    input  logic [7:0]                     scroll_y,
    output logic [$clog2(NUM_SPRITES)-1:0] spr_sel,
    input  logic [8:0]                     spr_x,
    input  logic [7:0]                     spr_y,
    input  logic [9:0]                     spr_idx,
    input  logic                           spr_priority,
    input  logic [1:0]                     spr_palette,
    input  logic                           spr_h16,
    input  logic                           spr_vflip,
    input  logic                           spr_hflip,
    output logic [13:0]                    vaddr,
    input  logic [15:0]                    vdata,
    input  logic [7:0]                     vline,
    input  logic                           start,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [8:0]                     cmd_idx,
    output logic [31:0]                    cmd_data,
    output logic                           cmd_is_sprite,
    output logic                           cmd_hflip,
    output logic [1:0]                     cmd_palette,
    output logic                           cmd_priority,
    output logic                           busy,
    output logic                           spr_overflow
);

    localparam int SW = $clog2(NUM_SPRITES);
    localparam int CW = $clog2(MAX_SPR_LINE + 1);
    localparam logic [SW-1:0] LAST_SPR = SW'(NUM_SPRITES - 1);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_MAP1 = 4'd1;
    localparam logic [3:0] S_MAP2 = 4'd2;
    localparam logic [3:0] S_PAT1 = 4'd3;
    localparam logic [3:0] S_PAT2 = 4'd4;
    localparam logic [3:0] S_BM1  = 4'd5;
    localparam logic [3:0] S_BM2  = 4'd6;
    localparam logic [3:0] S_BM3  = 4'd7;
    localparam logic [3:0] S_SPR  = 4'd8;
    localparam logic [3:0] S_DONE = 4'd9;

    logic [3:0]    state;
    logic [5:0]    col;        // tile-map column, wraps at 64
    logic [5:0]    col_cnt;    // columns fetched on this line
    logic [CW-1:0] spr_cnt;    // sprites issued on this line
    logic [8:0]    bg_idx;     // screen x of the next background command
    logic          spr_last;   // the sprite being fetched is the last table entry
    logic [15:0]   data_hi;    // first pattern word, waits for the second

    // Attributes of the group being fetched. They are copied to cmd_* only
    // when the command is issued, so a pending command is never disturbed by
    // the prefetch of the next one.
    logic [8:0]    pend_idx;
    logic          pend_is_sprite;
    logic          pend_hflip;
    logic [1:0]    pend_palette;
    logic          pend_priority;

    logic          pending;
    logic [7:0]    tline;
    logic [7:0]    ydiff;
    logic [3:0]    spr_height;
    logic          spr_online;
    logic [3:0]    spr_row;
    logic [13:0]   bm_addr;
    logic [15:0]   vdata_swapped;
    logic [3:0]    bg_end_state;

    assign pending       = cmd_valid && !cmd_ready;
    assign tline         = vline + scroll_y;
    assign ydiff         = vline - spr_y;
    assign spr_height    = spr_h16 ? 4'd15 : 4'd7;
    assign spr_online    = ydiff <= {4'd0, spr_height};
    assign spr_row       = spr_vflip ? (spr_height - ydiff[3:0]) : ydiff[3:0];
    assign bm_addr       = {6'd0, vline} * 14'd80 + {7'd0, col_cnt, 1'b0};
    assign vdata_swapped = {vdata[7:0], vdata[15:8]};
    assign bg_end_state  = sprites_enable ? S_SPR : S_DONE;

    // NOTE: every register here is updated with non-blocking assignments so
    // that all state changes at the clock edge from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_idx        <= '0;
            cmd_data       <= '0;
            cmd_is_sprite  <= 1'b0;
            cmd_hflip      <= 1'b0;
            cmd_palette    <= '0;
            cmd_priority   <= 1'b0;
            vaddr          <= '0;
            spr_sel        <= '0;
            spr_overflow   <= 1'b0;
            col            <= '0;
            col_cnt        <= '0;
            spr_cnt        <= '0;
            bg_idx         <= '0;
            spr_last       <= 1'b0;
            data_hi        <= '0;
            pend_idx       <= '0;
            pend_is_sprite <= 1'b0;
            pend_hflip     <= 1'b0;
            pend_palette   <= '0;
            pend_priority  <= 1'b0;
        end else if (start) begin
            // A new line abandons the current one, including any pending command.
            busy         <= 1'b1;
            cmd_valid    <= 1'b0;
            spr_overflow <= 1'b0;
            spr_sel      <= '0;
            col_cnt      <= '0;
            spr_cnt      <= '0;
            spr_last     <= 1'b0;
            col          <= scroll_x[8:3];
            bg_idx       <= tilemode ? (9'd0 - {6'd0, scroll_x[2:0]}) : 9'd0;
            state        <= tilemode ? S_MAP1 : S_BM1;
        end else begin
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            case (state)
                S_MAP1: begin
                    if (col_cnt == 6'(NUM_COLS)) begin
                        state <= bg_end_state;
                    end else begin
                        vaddr <= {3'b111, tline[7:3], col};
                        state <= S_MAP2;
                    end
                end

                S_MAP2: begin
                    pend_is_sprite <= 1'b0;
                    pend_hflip     <= vdata[11];
                    pend_palette   <= vdata[14:13];
                    pend_priority  <= vdata[15];
                    vaddr   <= {vdata[9:0], vdata[12] ? ~tline[2:0] : tline[2:0], 1'b0};
                    col     <= col + 6'd1;
                    col_cnt <= col_cnt + 6'd1;
                    state   <= S_PAT1;
                end

                S_BM1: begin
                    if (col_cnt == 6'd40) begin
                        state <= bg_end_state;
                    end else begin
                        pend_is_sprite <= 1'b0;
                        pend_hflip     <= 1'b0;
                        pend_palette   <= 2'd1;
                        pend_priority  <= 1'b0;
                        vaddr   <= bm_addr;
                        col_cnt <= col_cnt + 6'd1;
                        state   <= S_BM2;
                    end
                end

                S_PAT1, S_BM2: begin
                    data_hi  <= vdata_swapped;
                    vaddr[0] <= 1'b1;
                    state    <= (state == S_BM2) ? S_BM3 : S_PAT2;
                end

                S_PAT2, S_BM3: begin
                    // Issue as soon as the slot is free, including the cycle
                    // in which the previous command transfers.
                    if (!pending) begin
                        cmd_valid     <= 1'b1;
                        cmd_data      <= {data_hi, vdata_swapped};
                        cmd_is_sprite <= pend_is_sprite;
                        cmd_hflip     <= pend_hflip;
                        cmd_palette   <= pend_palette;
                        cmd_priority  <= pend_priority;
                        if (pend_is_sprite) begin
                            cmd_idx <= pend_idx;
                        end else begin
                            cmd_idx <= bg_idx;
                            bg_idx  <= bg_idx + 9'd8;
                        end
                        if (state == S_BM3)      state <= S_BM1;
                        else if (!pend_is_sprite) state <= S_MAP1;
                        else if (spr_last)        state <= S_DONE;
                        else                      state <= S_SPR;
                    end
                end

                S_SPR: begin
                    if (spr_online && spr_cnt == CW'(MAX_SPR_LINE)) begin
                        spr_overflow <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        if (spr_online) begin
                            vaddr <= {spr_idx[9:1], spr_idx[0] ^ spr_row[3], spr_row[2:0], 1'b0};
                            pend_idx       <= spr_x;
                            pend_is_sprite <= 1'b1;
                            pend_hflip     <= spr_hflip;
                            pend_palette   <= spr_palette;
                            pend_priority  <= spr_priority;
                            spr_cnt        <= spr_cnt + 1'b1;
                            state          <= S_PAT1;
                        end else if (spr_sel == LAST_SPR) begin
                            state <= S_DONE;
                        end
                        // The table is scanned once; the index never wraps.
                        spr_last <= (spr_sel == LAST_SPR);
                        if (spr_sel != LAST_SPR) begin
                            spr_sel <= spr_sel + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (!pending) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_fetch.sv
// -----------------------------------------------------------------------------
// tb_gfx_fetch -- self-checking bench for gfx_fetch.
// A table of background line configurations is run and every command is
// compared with a small reference model of the fetch addressing. Hand-written
// sequences then cover sprites, overflow, handshake stalls, restart and reset.
// -----------------------------------------------------------------------------
module tb_gfx_fetch;

    localparam int NSPR = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        tilemode, sprites_enable, start, cmd_ready;
    logic [8:0]  scroll_x;
    logic [7:0]  scroll_y, vline;
    logic [2:0]  spr_sel;
    logic [8:0]  spr_x;
    logic [7:0]  spr_y;
    logic [9:0]  spr_idx;
    logic        spr_priority, spr_h16, spr_vflip, spr_hflip;
    logic [1:0]  spr_palette;
    logic [13:0] vaddr;
    logic [15:0] vdata;
    logic        cmd_valid, cmd_is_sprite, cmd_hflip, cmd_priority, busy, spr_overflow;
    logic [8:0]  cmd_idx;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_palette;

    logic [8:0] tx   [NSPR];
    logic [7:0] ty   [NSPR];
    logic [9:0] tidx [NSPR];
    logic       tpri [NSPR];
    logic [1:0] tpal [NSPR];
    logic       th16 [NSPR];
    logic       tvf  [NSPR];
    logic       thf  [NSPR];

    typedef struct packed {
        logic [8:0]  idx;
        logic [31:0] data;
        logic        is_spr;
        logic        hflip;
        logic [1:0]  pal;
        logic        pri;
    } cmd_t;

    typedef struct {
        logic       tm;
        logic [8:0] sx;
        logic [7:0] sy;
        logic [7:0] vl;
        int         exp_n;
        logic [8:0] exp_idx0;
        logic [13:0] exp_va0;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    cmd_t got_q[$];
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    // VRAM: address-unique contents, read combinationally from vaddr.
    function automatic logic [15:0] vram_word(input logic [13:0] a);
        return 16'({2'b00, a} * 16'd40503 + 16'd12345);
    endfunction

    function automatic logic [15:0] swap(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    function automatic logic [31:0] pat_data(input logic [13:0] pa);
        return {swap(vram_word(pa)), swap(vram_word(pa | 14'd1))};
    endfunction

    assign vdata        = vram_word(vaddr);
    assign spr_x        = tx[spr_sel];
    assign spr_y        = ty[spr_sel];
    assign spr_idx      = tidx[spr_sel];
    assign spr_priority = tpri[spr_sel];
    assign spr_palette  = tpal[spr_sel];
    assign spr_h16      = th16[spr_sel];
    assign spr_vflip    = tvf[spr_sel];
    assign spr_hflip    = thf[spr_sel];

    gfx_fetch #(.NUM_SPRITES(NSPR), .MAX_SPR_LINE(2), .NUM_COLS(41)) dut (
        .clk(clk), .reset(reset), .tilemode(tilemode), .sprites_enable(sprites_enable),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .spr_sel(spr_sel),
        .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx), .spr_priority(spr_priority),
        .spr_palette(spr_palette), .spr_h16(spr_h16), .spr_vflip(spr_vflip),
        .spr_hflip(spr_hflip), .vaddr(vaddr), .vdata(vdata), .vline(vline),
        .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_idx(cmd_idx), .cmd_data(cmd_data), .cmd_is_sprite(cmd_is_sprite),
        .cmd_hflip(cmd_hflip), .cmd_palette(cmd_palette), .cmd_priority(cmd_priority),
        .busy(busy), .spr_overflow(spr_overflow)
    );

    // Record every transfer; sampled half a cycle before the edge that performs it.
    always @(negedge clk) begin
        if (mon_en && cmd_valid && cmd_ready) begin
            got_q.push_back({cmd_idx, cmd_data, cmd_is_sprite, cmd_hflip, cmd_palette, cmd_priority});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected k-th background command of a line.
    function automatic cmd_t bg_model(input logic tm, input logic [8:0] sx, input logic [7:0] sy,
                                      input logic [7:0] vl, input int k);
        cmd_t        c;
        logic [5:0]  col;
        logic [7:0]  tl;
        logic [15:0] e;
        logic [2:0]  r;
        logic [13:0] pa;
        if (tm) begin
            col     = sx[8:3] + 6'(k);
            tl      = vl + sy;
            e       = vram_word({3'b111, tl[7:3], col});
            r       = e[12] ? ~tl[2:0] : tl[2:0];
            pa      = {e[9:0], r, 1'b0};
            c.idx   = 9'(512 - int'(sx[2:0]) + 8 * k);
            c.hflip = e[11];
            c.pal   = e[14:13];
            c.pri   = e[15];
        end else begin
            pa      = 14'(int'(vl) * 80 + 2 * k);
            c.idx   = 9'(8 * k);
            c.hflip = 1'b0;
            c.pal   = 2'd1;
            c.pri   = 1'b0;
        end
        c.data   = pat_data(pa);
        c.is_spr = 1'b0;
        return c;
    endfunction

    function automatic cmd_t spr_model(input logic [8:0] x, input logic [13:0] pa,
                                       input logic hf, input logic [1:0] pal, input logic pri);
        cmd_t c;
        c.idx    = x;
        c.data   = pat_data(pa);
        c.is_spr = 1'b1;
        c.hflip  = hf;
        c.pal    = pal;
        c.pri    = pri;
        return c;
    endfunction

    task automatic start_line(input logic tm, input logic [8:0] sx, input logic [7:0] sy,
                              input logic [7:0] vl, input logic se);
        tilemode = tm; scroll_x = sx; scroll_y = sy; vline = vl; sprites_enable = se;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 4000) begin
            tick();
            n++;
        end
        check({name, " busy falls"}, 64'(busy), 64'(0));
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!cmd_valid && n < 200) begin
            tick();
            n++;
        end
        check({name, " cmd_valid seen"}, 64'(cmd_valid), 64'(1));
    endtask

    task automatic check_bg(input string name, input logic tm, input logic [8:0] sx,
                            input logic [7:0] sy, input logic [7:0] vl, input int n);
        for (int k = 0; k < n && k < got_q.size(); k++) begin
            check($sformatf("%s cmd%0d", name, k), 64'(got_q[k]), 64'(bg_model(tm, sx, sy, vl, k)));
        end
    endtask

    task automatic set_far(input logic [7:0] vl);
        for (int i = 0; i < NSPR; i++) begin
            tx[i] = '0; ty[i] = vl + 8'd100; tidx[i] = '0; tpri[i] = 1'b0;
            tpal[i] = '0; th16[i] = 1'b1; tvf[i] = 1'b0; thf[i] = 1'b0;
        end
    endtask

    vec_t vecs[5];
    cmd_t snap;
    bit   stable;

    initial begin
        vecs[0] = '{1'b1, 9'd5,   8'd0,   8'd0,   41, 9'd507, 14'h3800};
        vecs[1] = '{1'b1, 9'd19,  8'd10,  8'd30,  41, 9'd509, 14'h3942};
        vecs[2] = '{1'b1, 9'd511, 8'd240, 8'd32,  41, 9'd505, 14'h38BF};
        vecs[3] = '{1'b0, 9'd0,   8'd0,   8'd3,   40, 9'd0,   14'd240};
        vecs[4] = '{1'b0, 9'd100, 8'd7,   8'd255, 40, 9'd0,   14'd4016};

        reset = 1'b1; start = 1'b0; cmd_ready = 1'b1; tilemode = 1'b0;
        sprites_enable = 1'b0; scroll_x = '0; scroll_y = '0; vline = '0;
        set_far(8'd0);
        tick();
        tick();
        check("reset busy", 64'(busy), 64'(0));
        check("reset cmd_valid", 64'(cmd_valid), 64'(0));
        check("reset payload", 64'({cmd_idx, cmd_data, cmd_is_sprite, cmd_hflip, cmd_palette, cmd_priority}), 64'(0));
        check("reset vaddr/spr_sel/ovf", 64'({vaddr, spr_sel, spr_overflow}), 64'(0));
        reset = 1'b0;
        tick();

        // Background lines from the table.
        for (int i = 0; i < 5; i++) begin
            got_q.delete();
            mon_en = 1'b1;
            start_line(vecs[i].tm, vecs[i].sx, vecs[i].sy, vecs[i].vl, 1'b0);
            check($sformatf("v%0d busy after start", i), 64'(busy), 64'(1));
            tick();
            check($sformatf("v%0d first vaddr", i), 64'(vaddr), 64'(vecs[i].exp_va0));
            wait_idle($sformatf("v%0d", i));
            check($sformatf("v%0d count", i), 64'(got_q.size()), 64'(vecs[i].exp_n));
            if (got_q.size() > 0)
                check($sformatf("v%0d first idx", i), 64'(got_q[0].idx), 64'(vecs[i].exp_idx0));
            check_bg($sformatf("v%0d", i), vecs[i].tm, vecs[i].sx, vecs[i].sy, vecs[i].vl, vecs[i].exp_n);
            check($sformatf("v%0d cmd_valid idle", i), 64'(cmd_valid), 64'(0));
        end

        // Sprite limit: three on-line sprites, only two may issue.
        set_far(8'd60);
        tx[0] = 9'd10; ty[0] = 8'd60; tidx[0] = 10'h010; th16[0] = 1'b0; thf[0] = 1'b1; tpal[0] = 2'd3; tpri[0] = 1'b1;
        tx[1] = 9'd20; ty[1] = 8'd60; tidx[1] = 10'h020; th16[1] = 1'b0; tpal[1] = 2'd2;
        tx[2] = 9'd30; ty[2] = 8'd60; tidx[2] = 10'h030; th16[2] = 1'b0;
        got_q.delete();
        start_line(1'b0, 9'd0, 8'd0, 8'd60, 1'b1);
        wait_idle("ovf");
        check("ovf count", 64'(got_q.size()), 64'(42));
        check_bg("ovf", 1'b0, 9'd0, 8'd0, 8'd60, 40);
        if (got_q.size() >= 42) begin
            check("ovf spr0", 64'(got_q[40]), 64'(spr_model(9'd10, 14'h100, 1'b1, 2'd3, 1'b1)));
            check("ovf spr1", 64'(got_q[41]), 64'(spr_model(9'd20, 14'h200, 1'b0, 2'd2, 1'b0)));
        end
        check("ovf flag", 64'(spr_overflow), 64'(1));

        // Start mid-line with a stalled command: command withdrawn, line restarts.
        cmd_ready = 1'b0;
        got_q.delete();
        start_line(1'b1, 9'd5, 8'd0, 8'd0, 1'b0);
        check("restart ovf cleared", 64'(spr_overflow), 64'(0));
        wait_valid("restart");
        check("restart pending idx", 64'(cmd_idx), 64'(507));
        start_line(1'b1, 9'd5, 8'd0, 8'd0, 1'b0);
        check("restart withdraw", 64'(cmd_valid), 64'(0));
        cmd_ready = 1'b1;
        wait_idle("restart");
        check("restart count", 64'(got_q.size()), 64'(41));
        check_bg("restart", 1'b1, 9'd5, 8'd0, 8'd0, 41);

        // Sprite rows: 16-high vflip, 8-high boundary miss, bottom row of last sprite.
        set_far(8'd50);
        tx[3] = 9'd100; ty[3] = 8'd48; tidx[3] = 10'h004; th16[3] = 1'b1; tvf[3] = 1'b1;
        thf[3] = 1'b1; tpal[3] = 2'd2; tpri[3] = 1'b1;
        tx[5] = 9'd200; ty[5] = 8'd42; tidx[5] = 10'h3FF; th16[5] = 1'b0;
        tx[7] = 9'd300; ty[7] = 8'd35; tidx[7] = 10'h0C1; th16[7] = 1'b1;
        got_q.delete();
        start_line(1'b0, 9'd0, 8'd0, 8'd50, 1'b1);
        wait_idle("rows");
        check("rows count", 64'(got_q.size()), 64'(42));
        if (got_q.size() >= 42) begin
            check("rows spr3 vflip h16", 64'(got_q[40]), 64'(spr_model(9'd100, 14'h05A, 1'b1, 2'd2, 1'b1)));
            check("rows spr7 last row", 64'(got_q[41]), 64'(spr_model(9'd300, 14'h0C0E, 1'b0, 2'd0, 1'b0)));
        end
        check("rows no overflow", 64'(spr_overflow), 64'(0));

        // Back-pressure on the third command for 20 cycles.
        set_far(8'd3);
        cmd_ready = 1'b0;
        got_q.delete();
        start_line(1'b0, 9'd0, 8'd0, 8'd3, 1'b0);
        for (int c = 0; c < 2; c++) begin
            wait_valid($sformatf("stall cmd%0d", c));
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
        end
        wait_valid("stall cmd2");
        snap   = {cmd_idx, cmd_data, cmd_is_sprite, cmd_hflip, cmd_palette, cmd_priority};
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!cmd_valid || snap !== {cmd_idx, cmd_data, cmd_is_sprite, cmd_hflip, cmd_palette, cmd_priority})
                stable = 1'b0;
        end
        check("stall payload stable", 64'(stable), 64'(1));
        check("stall held idx", 64'(snap.idx), 64'(16));
        check("stall vaddr prefetch", 64'(vaddr), 64'(247));
        check("stall transfers", 64'(got_q.size()), 64'(2));
        cmd_ready = 1'b1;
        wait_idle("stall");
        check("stall count", 64'(got_q.size()), 64'(40));
        check_bg("stall", 1'b0, 9'd0, 8'd0, 8'd3, 40);

        // Reset in the middle of a line.
        got_q.delete();
        start_line(1'b0, 9'd0, 8'd0, 8'd9, 1'b0);
        repeat (30) tick();
        reset = 1'b1;
        #1;
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset cmd_valid/vaddr", 64'({cmd_valid, vaddr}), 64'(0));
        tick();
        reset = 1'b0;
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (cmd_valid || busy) stable = 1'b0;
        end
        check("midreset stays idle", 64'(stable), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
